// File: rtl/display_pkg.sv
// Shared constants, converter state encoding and the double-dabble step
// used by the thermostat temperature display stage.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam int BIN_W      = 16;
  localparam int BCD_W      = 20;
  localparam int ITER_COUNT = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } conv_state_t;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
  function automatic logic [BIN_W+BCD_W-1:0] dabble_step(input logic [BIN_W+BCD_W-1:0] w);
    logic [BIN_W+BCD_W-1:0] t;
    t = w;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5) t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
    end
    return {t[BIN_W+BCD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_converter_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter, one double-dabble
// iteration per clock; a start in any state restarts from fresh data.
module bcd_converter_seq
  import display_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t              state, state_next;
  logic [BIN_W+BCD_W-1:0]   work;
  logic [3:0]               iter;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      iter  <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        work <= {{BCD_W{1'b0}}, bin};
        iter <= '0;
      end else if (state == CONVERT) begin
        work <= dabble_step(work);
        iter <= iter + 4'd1;
      end
    end
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: begin
        if (start)                                state_next = CONVERT;
        else if (iter == 4'(ITER_COUNT - 1))      state_next = DONE;
      end
      DONE:    state_next = start ? CONVERT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pending start counts as busy, so a DONE coinciding with a restart is dropped.
  assign busy = (state == CONVERT) || start;
  assign done = (state == DONE);
  assign bcd  = work[BIN_W+BCD_W-1:BIN_W];

endmodule

// File: rtl/seven_segment_decode_decimal.sv
// Decimal digit to {a,b,c,d,e,f,g} active-high segment pattern; non-decimal
// codes produce a blank digit.
module seven_segment_decode_decimal (
  input  logic [3:0] digit,
  output logic [6:0] abcdefg
);

  always_comb begin
    case (digit)
      4'd0:    abcdefg = 7'b1111110;
      4'd1:    abcdefg = 7'b0110000;
      4'd2:    abcdefg = 7'b1101101;
      4'd3:    abcdefg = 7'b1111001;
      4'd4:    abcdefg = 7'b0110011;
      4'd5:    abcdefg = 7'b1011011;
      4'd6:    abcdefg = 7'b1011111;
      4'd7:    abcdefg = 7'b1110000;
      4'd8:    abcdefg = 7'b1111111;
      4'd9:    abcdefg = 7'b1111011;
      default: abcdefg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/temp_display_driver.sv
// Captures decoded thermostat frames, converts the selected temperature to
// BCD and drives a multiplexed 4-digit common-cathode seven-segment display.
module temp_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_BITS = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_done,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic        show_set,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  digit_sel,
  output logic        have_data
);

  logic                    fd_meta, fd_sync, fd_prev;
  logic                    ss_meta, ss_sync, ss_sel;
  logic [15:0]             room_shadow, set_shadow;
  logic                    start_req;
  logic                    capture, sel_change, commit;
  logic                    conv_busy, conv_done;
  logic [BCD_W-1:0]        conv_bcd;
  logic [15:0]             disp_bcd;
  logic                    disp_dash;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              digit_idx;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg, seg_next;

  assign capture    = fd_sync & ~fd_prev;
  assign sel_change = ss_sync ^ ss_sel;
  assign commit     = conv_done & ~conv_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {fd_meta, fd_sync, fd_prev} <= '0;
      {ss_meta, ss_sync, ss_sel}  <= '0;
      room_shadow <= '0;
      set_shadow  <= '0;
      start_req   <= 1'b0;
    end else begin
      {fd_meta, fd_sync, fd_prev} <= {frame_done, fd_meta, fd_sync};
      {ss_meta, ss_sync, ss_sel}  <= {show_set, ss_meta, ss_sync};
      if (capture) begin
        room_shadow <= room_temp;
        set_shadow  <= set_temp;
      end
      start_req <= capture | (sel_change & have_data);
    end
  end

  bcd_converter_seq u_conv (
    .clock (clock),
    .reset (reset),
    .start (start_req),
    .bin   (ss_sel ? set_shadow : room_shadow),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display register: digits and overflow flag change together on commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_bcd  <= '0;
      disp_dash <= 1'b0;
      have_data <= 1'b0;
    end else if (commit) begin
      disp_bcd  <= conv_bcd[15:0];
      disp_dash <= (conv_bcd[19:16] != 4'd0);
      have_data <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      if (&refresh_cnt) digit_idx <= digit_idx + 2'd1;
    end
  end

  assign cur_digit = disp_bcd[{digit_idx, 2'b00} +: 4];

  seven_segment_decode_decimal u_dec (
    .digit   (cur_digit),
    .abcdefg (dec_seg)
  );

  always_comb begin
    seg_next = dec_seg;
    if (!have_data || disp_dash)                 seg_next = SEG_DASH;
    else if (digit_idx == 2'd3 && cur_digit == 4'd0) seg_next = SEG_BLANK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg       <= SEG_DASH;
      dp        <= 1'b0;
      digit_sel <= 4'b0001;
    end else begin
      seg       <= seg_next;
      dp        <= have_data && !disp_dash && (digit_idx == 2'd1);
      digit_sel <= 4'b0001 << digit_idx;
    end
  end

endmodule

// File: tb/tb_temp_display_driver.sv
// Self-checking bench for temp_display_driver: a cycle-level behavioural model
// of the displayed value plus literal digit checks for the directed cases.
module tb_temp_display_driver;

  localparam int          RB         = 4;
  localparam int          DIGIT_CLKS = 1 << RB;
  localparam logic [6:0]  DASH       = 7'b0000001;
  localparam logic [6:0]  BLANK      = 7'b0000000;

  logic        clock, reset, frame_done, show_set;
  logic [15:0] room_temp, set_temp;
  logic [6:0]  seg;
  logic        dp, have_data;
  logic [3:0]  digit_sel;

  int tests = 0;
  int fails = 0;

  temp_display_driver #(.REFRESH_BITS(RB)) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_done (frame_done),
    .room_temp  (room_temp),
    .set_temp   (set_temp),
    .show_set   (show_set),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .have_data  (have_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  function automatic int p10(input int pos);
    case (pos)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit hv, input int pos);
    int dig;
    if (!hv || v > 9999) return DASH;
    dig = (v / p10(pos)) % 10;
    if (pos == 3 && dig == 0) return BLANK;
    return pattern(dig);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  // Behavioural model: 3 clocks to capture, 18 clocks from capture/selection
  // start to commit, a later start replaces any pending conversion.
  int n, room_sh, set_sh, pend_at, pend_val, disp_val, prev_disp_val;
  bit f1, f2, f3, s1, s2, s3, sel, pend_valid, have, prev_have, had, cap, chg;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      n = 0;
      {f1, f2, f3, s1, s2, s3} = '0;
      room_sh = 0; set_sh = 0; sel = 0;
      pend_valid = 0; pend_at = 0; pend_val = 0;
      disp_val = 0; have = 0; prev_disp_val = 0; prev_have = 0;
    end else begin
      n++;
      prev_disp_val = disp_val;
      prev_have     = have;
      had           = have;
      cap = f2 && !f3;
      chg = (s2 != s3);
      if (pend_valid && n == pend_at) begin
        disp_val   = pend_val;
        have       = 1;
        pend_valid = 0;
      end
      if (cap) begin
        room_sh = room_temp;
        set_sh  = set_temp;
      end
      if (chg) sel = s2;
      if (cap || (chg && had)) begin
        pend_valid = 1;
        pend_at    = n + 18;
        pend_val   = sel ? set_sh : room_sh;
      end
      f3 = f2; f2 = f1; f1 = frame_done;
      s3 = s2; s2 = s1; s1 = show_set;
    end
  end

  int cmp_pos;
  always @(posedge clock) begin
    #1;
    if (!reset && n >= 1) begin
      cmp_pos = ((n - 1) / DIGIT_CLKS) % 4;
      check("model_seg", seg, exp_seg(prev_disp_val, prev_have, cmp_pos));
      check("model_dp", dp, prev_have && prev_disp_val <= 9999 && cmp_pos == 1);
      check("model_sel", digit_sel, 4'b0001 << cmp_pos);
      check("model_have", have_data, have);
    end
  end

  task automatic settle(input int c);
    repeat (c) @(negedge clock);
  endtask

  task automatic pulse_frame(input int room, input int setv, input bit toggle);
    @(negedge clock);
    room_temp  = 16'(room);
    set_temp   = 16'(setv);
    frame_done = 1'b1;
    if (toggle) show_set = ~show_set;
    settle(4);
    frame_done = 1'b0;
  endtask

  task automatic expect_digit(input int pos, input logic [6:0] s, input logic p);
    int k;
    k = 0;
    @(negedge clock);
    while (digit_sel !== (4'b0001 << pos) && k < 4 * DIGIT_CLKS + 8) begin
      @(negedge clock);
      k++;
    end
    check("digit_wait", digit_sel, 4'b0001 << pos);
    check("lit_seg", seg, s);
    check("lit_dp", dp, p);
  endtask

  initial begin
    reset = 1'b1; frame_done = 1'b0; show_set = 1'b0;
    room_temp = '0; set_temp = '0;
    settle(3);
    check("rst_seg", seg, DASH);
    check("rst_dp", dp, 0);
    check("rst_sel", digit_sel, 4'b0001);
    check("rst_have", have_data, 0);
    reset = 1'b0;

    for (int d = 0; d < 4; d++) expect_digit(d, DASH, 1'b0);
    check("idle_have", have_data, 0);

    pulse_frame(723, 685, 1'b0);
    settle(30);
    expect_digit(3, BLANK, 1'b0);
    expect_digit(2, 7'b1110000, 1'b0);
    expect_digit(1, 7'b1101101, 1'b1);
    expect_digit(0, 7'b1111001, 1'b0);
    check("have_723", have_data, 1);

    @(negedge clock);
    show_set = 1'b1;
    settle(30);
    expect_digit(3, BLANK, 1'b0);
    expect_digit(2, 7'b1011111, 1'b0);
    expect_digit(1, 7'b1111111, 1'b1);
    expect_digit(0, 7'b1011011, 1'b0);

    @(negedge clock);
    show_set = 1'b0;
    settle(30);
    pulse_frame(10000, 685, 1'b0);
    settle(30);
    for (int d = 0; d < 4; d++) expect_digit(d, DASH, 1'b0);

    pulse_frame(9999, 685, 1'b0);
    settle(30);
    for (int d = 3; d >= 0; d--) expect_digit(d, 7'b1111011, d == 1);

    // Second frame lands while the first is mid-conversion.
    pulse_frame(1234, 685, 1'b0);
    settle(7);
    pulse_frame(4321, 685, 1'b0);
    settle(30);
    expect_digit(3, 7'b0110011, 1'b0);
    expect_digit(2, 7'b1111001, 1'b0);
    expect_digit(1, 7'b1101101, 1'b1);
    expect_digit(0, 7'b0110000, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    pulse_frame(5555, 0, 1'b0);
    settle(6);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_seg", seg, DASH);
    check("arst_dp", dp, 0);
    check("arst_sel", digit_sel, 4'b0001);
    check("arst_have", have_data, 0);
    @(negedge clock);
    reset = 1'b0;
    settle(2);

    @(negedge clock);
    room_temp  = 16'd42;
    frame_done = 1'b1;
    settle(20);
    check("lat_before", have_data, 0);
    settle(1);
    check("lat_after", have_data, 1);
    frame_done = 1'b0;
    expect_digit(2, 7'b1111110, 1'b0);
    expect_digit(1, 7'b0110011, 1'b1);
    expect_digit(0, 7'b1101101, 1'b0);

    for (int i = 0; i < 24; i++) begin
      pulse_frame($urandom_range(0, 11000), $urandom_range(0, 11000), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        settle($urandom_range(2, 12));
        show_set = ~show_set;
      end
      settle($urandom_range(6, 40));
    end
    settle(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
